// File: rtl/nios2_mul_pkg.sv
// Shared constants, state encoding, adder operand selects and helpers for the Nios II
// multiplier result assembler.
package nios2_mul_pkg;

  localparam int unsigned DataW = 32;
  localparam int unsigned HalfW = 16;
  localparam int unsigned MidW  = DataW + 2;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StMid  = 3'd1;
  localparam logic [2:0] StLo   = 3'd2;
  localparam logic [2:0] StHi   = 3'd3;
  localparam logic [2:0] StDone = 3'd4;

  localparam logic [1:0] AddMid = 2'd0;
  localparam logic [1:0] AddLo  = 2'd1;
  localparam logic [1:0] AddHi  = 2'd2;

  // Mul op encoding: {src1_signed, src2_signed, sel_hi}
  localparam logic [2:0] MulOpMul    = 3'b000;
  localparam logic [2:0] MulOpMulxss = 3'b111;
  localparam logic [2:0] MulOpMulxsu = 3'b101;
  localparam logic [2:0] MulOpMulxuu = 3'b001;

  function automatic logic [MidW-1:0] ext34(input logic [DataW-1:0] v, input logic is_signed);
    return {{(MidW - DataW){is_signed & v[DataW-1]}}, v};
  endfunction

endpackage

// File: rtl/nios2_mul_asm_adder.sv
// Shared 34-bit adder for the result assembler: picks the MID, LO or HI operand pair and
// applies the carry-in only for the HI step.
module nios2_mul_asm_adder
  import nios2_mul_pkg::*;
(
  input  logic [1:0]      sel,
  input  logic [MidW-1:0] a_mid,
  input  logic [MidW-1:0] b_mid,
  input  logic [MidW-1:0] a_lo,
  input  logic [MidW-1:0] b_lo,
  input  logic [MidW-1:0] a_hi,
  input  logic [MidW-1:0] b_hi,
  input  logic            cin,
  output logic [MidW-1:0] sum
);

  logic [MidW-1:0] op_a;
  logic [MidW-1:0] op_b;
  logic            op_c;

  always_comb begin
    op_a = '0;
    op_b = '0;
    op_c = 1'b0;
    case (sel)
      AddMid: begin
        op_a = a_mid;
        op_b = b_mid;
      end
      AddLo: begin
        op_a = a_lo;
        op_b = b_lo;
      end
      AddHi: begin
        op_a = a_hi;
        op_b = b_hi;
        op_c = cin;
      end
      default: ;
    endcase
  end

  assign sum = op_a + op_b + {{(MidW - 1){1'b0}}, op_c};

endmodule

// File: rtl/nios2_mul_result_assembler.sv
// Reduces the four 16x16 partial products to a 64-bit product and returns one 32-bit word.
// NIOS2_MUL_ASM_SINGLE_CYCLE_EN selects a combinational 1-cycle reduction over the 5-state FSM.
module nios2_mul_result_assembler
  import nios2_mul_pkg::*;
#(
  parameter int unsigned DATA_W = DataW,
  parameter int unsigned HALF_W = HalfW
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] M_mul_cell_p1,
  input  logic [DATA_W-1:0] M_mul_cell_p2,
  input  logic [DATA_W-1:0] M_mul_cell_p3,
  input  logic [DATA_W-1:0] M_mul_cell_p4,
  input  logic              src1_signed,
  input  logic              src2_signed,
  input  logic              sel_hi,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              busy
);

  logic [DATA_W-1:0] p1_q, p2_q, p3_q, p4_q;
  logic              s1_q, s2_q, sel_hi_q;
  logic [2:0]        state_q, state_d;
  logic              in_xfer;

  logic [MidW-1:0]   a_mid, b_mid, a_lo, b_lo, a_hi, b_hi;
  logic [MidW-1:0]   mid_v;
  logic [HALF_W:0]   lo_v;
  logic [DATA_W-1:0] lo_word;

  assign in_xfer = in_valid && in_ready;

  assign a_mid   = ext34(p2_q, s2_q);
  assign b_mid   = ext34(p3_q, s1_q);
  assign a_lo    = {{(MidW - HALF_W){1'b0}}, p1_q[DATA_W-1:HALF_W]};
  assign b_lo    = {{(MidW - HALF_W){1'b0}}, mid_v[HALF_W-1:0]};
  assign a_hi    = {{(MidW - DATA_W){1'b0}}, p4_q};
  // Arithmetic shift of mid by HALF_W, sign-extended back to full adder width.
  assign b_hi    = {{HALF_W{mid_v[MidW-1]}}, mid_v[MidW-1:HALF_W]};
  assign lo_word = {lo_v[HALF_W-1:0], p1_q[HALF_W-1:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p1_q     <= '0;
      p2_q     <= '0;
      p3_q     <= '0;
      p4_q     <= '0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      sel_hi_q <= 1'b0;
      state_q  <= StIdle;
    end else begin
      state_q <= state_d;
      if (in_xfer) begin
        p1_q     <= M_mul_cell_p1;
        p2_q     <= M_mul_cell_p2;
        p3_q     <= M_mul_cell_p3;
        p4_q     <= M_mul_cell_p4;
        s1_q     <= src1_signed;
        s2_q     <= src2_signed;
        sel_hi_q <= sel_hi;
      end
    end
  end

`ifdef NIOS2_MUL_ASM_SINGLE_CYCLE_EN

  logic [MidW-1:0] mid_sum, lo_sum, hi_sum;

  nios2_mul_asm_adder u_add_mid (
    .sel   (AddMid),
    .a_mid (a_mid),
    .b_mid (b_mid),
    .a_lo  ('0),
    .b_lo  ('0),
    .a_hi  ('0),
    .b_hi  ('0),
    .cin   (1'b0),
    .sum   (mid_sum)
  );

  nios2_mul_asm_adder u_add_lo (
    .sel   (AddLo),
    .a_mid ('0),
    .b_mid ('0),
    .a_lo  (a_lo),
    .b_lo  (b_lo),
    .a_hi  ('0),
    .b_hi  ('0),
    .cin   (1'b0),
    .sum   (lo_sum)
  );

  nios2_mul_asm_adder u_add_hi (
    .sel   (AddHi),
    .a_mid ('0),
    .b_mid ('0),
    .a_lo  ('0),
    .b_lo  ('0),
    .a_hi  (a_hi),
    .b_hi  (b_hi),
    .cin   (lo_sum[HALF_W]),
    .sum   (hi_sum)
  );

  assign mid_v = mid_sum;
  assign lo_v  = lo_sum[HALF_W:0];

  // A fresh input may land in the same cycle the held result is consumed.
  always_comb begin
    state_d = state_q;
    if (in_xfer) begin
      state_d = StDone;
    end else if (out_ready) begin
      state_d = StIdle;
    end
  end

  assign out_valid = (state_q == StDone);
  assign in_ready  = !out_valid || out_ready;
  assign busy      = out_valid;
  assign result    = sel_hi_q ? hi_sum[DATA_W-1:0] : lo_word;

`else

  logic [MidW-1:0]   mid_q;
  logic [HALF_W:0]   lo_q;
  logic [DATA_W-1:0] result_q;
  logic [1:0]        add_sel;
  logic [MidW-1:0]   add_sum;

  always_comb begin
    add_sel = AddMid;
    case (state_q)
      StLo:    add_sel = AddLo;
      StHi:    add_sel = AddHi;
      default: add_sel = AddMid;
    endcase
  end

  nios2_mul_asm_adder u_adder (
    .sel   (add_sel),
    .a_mid (a_mid),
    .b_mid (b_mid),
    .a_lo  (a_lo),
    .b_lo  (b_lo),
    .a_hi  (a_hi),
    .b_hi  (b_hi),
    .cin   (lo_q[HALF_W]),
    .sum   (add_sum)
  );

  assign mid_v = mid_q;
  assign lo_v  = lo_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (in_valid) state_d = StMid;
      StMid:   state_d = StLo;
      StLo:    state_d = StHi;
      StHi:    state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mid_q    <= '0;
      lo_q     <= '0;
      result_q <= '0;
    end else begin
      if (state_q == StMid) mid_q <= add_sum;
      if (state_q == StLo)  lo_q  <= add_sum[HALF_W:0];
      if (state_q == StHi)  result_q <= sel_hi_q ? add_sum[DATA_W-1:0] : lo_word;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign result    = result_q;

`endif

endmodule

// File: tb/tb_nios2_mul_result_assembler.sv
// Self-checking bench for nios2_mul_result_assembler; expectations come from a 64-bit
// multiply model. Latency expectation follows NIOS2_MUL_ASM_SINGLE_CYCLE_EN.
module tb_nios2_mul_result_assembler;

`ifdef NIOS2_MUL_ASM_SINGLE_CYCLE_EN
  localparam int Lat = 1;
`else
  localparam int Lat = 4;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic        src1_signed, src2_signed, sel_hi;
  logic [31:0] p1, p2, p3, p4, result;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  nios2_mul_result_assembler dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .M_mul_cell_p1 (p1),
    .M_mul_cell_p2 (p2),
    .M_mul_cell_p3 (p3),
    .M_mul_cell_p4 (p4),
    .src1_signed   (src1_signed),
    .src2_signed   (src2_signed),
    .sel_hi        (sel_hi),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .result        (result),
    .busy          (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, want);
    end
  endtask

  function automatic logic [63:0] sx(input logic [31:0] v, input logic s);
    return s ? {{32{v[31]}}, v} : {32'b0, v};
  endfunction

  function automatic logic [63:0] sx16(input logic [15:0] v, input logic s);
    return s ? {{48{v[15]}}, v} : {48'b0, v};
  endfunction

  // Reference: full-width product of the extended operands.
  function automatic logic [31:0] ref_word(input logic [31:0] a, input logic [31:0] b,
                                           input logic sa, input logic sb, input logic hi);
    logic [63:0] prod;
    prod = sx(a, sa) * sx(b, sb);
    return hi ? prod[63:32] : prod[31:0];
  endfunction

  task automatic partials(input logic [31:0] a, input logic [31:0] b, input logic sa,
                          input logic sb, output logic [31:0] q1, output logic [31:0] q2,
                          output logic [31:0] q3, output logic [31:0] q4);
    logic [63:0] t;
    t = sx16(a[15:0], 1'b0) * sx16(b[15:0], 1'b0);  q1 = t[31:0];
    t = sx16(a[15:0], 1'b0) * sx16(b[31:16], sb);   q2 = t[31:0];
    t = sx16(a[31:16], sa) * sx16(b[15:0], 1'b0);   q3 = t[31:0];
    t = sx16(a[31:16], sa) * sx16(b[31:16], sb);    q4 = t[31:0];
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic do_op(input string tag, input logic [31:0] a1, input logic [31:0] a2,
                       input logic [31:0] a3, input logic [31:0] a4, input logic f1,
                       input logic f2, input logic fs, input logic [31:0] want);
    int lat;
    p1 = a1; p2 = a2; p3 = a3; p4 = a4;
    src1_signed = f1; src2_signed = f2; sel_hi = fs;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    p1 = $urandom; p2 = $urandom; p3 = $urandom; p4 = $urandom;
    src1_signed = ~f1; src2_signed = ~f2; sel_hi = ~fs;
    check({tag, " busy_after_accept"}, busy, 1);
    check({tag, " in_ready_after_accept"}, in_ready, 0);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, lat, Lat);
    check({tag, " result"}, result, want);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " out_valid_after_take"}, out_valid, 0);
    check({tag, " busy_after_take"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b, q1, q2, q3, q4, hold;
    logic        sa, sb, sh;
    int          lat;

    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    p1 = '0; p2 = '0; p3 = '0; p4 = '0;
    src1_signed = 1'b0; src2_signed = 1'b0; sel_hi = 1'b0;
    #2;
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset result", result, 0);
    check("reset busy", busy, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    do_op("uu_lo", 32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 0, 0, 0, 32'h1);
    do_op("uu_hi", 32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 0, 0, 1,
          32'hFFFFFFFE);
    do_op("ss_hi", 32'hFFFE0001, 32'hFFFF0001, 32'hFFFF0001, 32'h1, 1, 1, 1, 32'h0);
    do_op("ss_lo", 32'hFFFE0001, 32'hFFFF0001, 32'hFFFF0001, 32'h1, 1, 1, 0, 32'h1);
    do_op("su_hi", 32'h0, 32'h0, 32'hFFFF0000, 32'h0, 1, 0, 1, 32'hFFFFFFFF);

    // Back-pressure: result held, new input refused until the result is taken.
    p1 = 32'hFFFE0001; p2 = 32'hFFFE0001; p3 = 32'hFFFE0001; p4 = 32'hFFFE0001;
    src1_signed = 1'b0; src2_signed = 1'b0; sel_hi = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("bp latency", lat, Lat);
    check("bp result", result, 32'hFFFFFFFE);
    p1 = 32'hFFFE0001; p2 = 32'hFFFF0001; p3 = 32'hFFFF0001; p4 = 32'h1;
    src1_signed = 1'b1; src2_signed = 1'b1; sel_hi = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("bp hold out_valid", out_valid, 1);
      check("bp hold result", result, 32'hFFFFFFFE);
      check("bp hold in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp ignored input busy", busy, 0);
    check("bp ignored input out_valid", out_valid, 0);

    // Asynchronous reset two cycles after accept (LO state in iterative mode).
    hold = result;
    check("pre-reset result nonzero", (hold != 0), 1);
    p1 = 32'hFFFE0001; p2 = 32'hFFFE0001; p3 = 32'hFFFE0001; p4 = 32'hFFFE0001;
    src1_signed = 1'b0; src2_signed = 1'b0; sel_hi = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midop reset out_valid", out_valid, 0);
    check("midop reset in_ready", in_ready, 1);
    check("midop reset result", result, 0);
    check("midop reset busy", busy, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    do_op("post_reset", 32'h0, 32'h0, 32'hFFFF0000, 32'h0, 1, 0, 1, 32'hFFFFFFFF);

    // Randomized operands against the 64-bit model.
    for (int i = 0; i < 24; i++) begin
      a = $urandom; b = $urandom;
      if (i % 6 == 0) a = 32'h80000000;
      if (i % 7 == 1) b = 32'hFFFFFFFF;
      sa = 1'($urandom_range(0, 1));
      sb = 1'($urandom_range(0, 1));
      sh = 1'($urandom_range(0, 1));
      partials(a, b, sa, sb, q1, q2, q3, q4);
      do_op($sformatf("rand%0d a=%h b=%h s=%b%b%b", i, a, b, sa, sb, sh), q1, q2, q3, q4,
            sa, sb, sh, ref_word(a, b, sa, sb, sh));
    end

`ifdef NIOS2_MUL_ASM_SINGLE_CYCLE_EN
    // Back-to-back: one input accepted and one result produced every cycle.
    begin
      logic [31:0] tp1 [4] = '{32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 32'h0};
      logic [31:0] tp2 [4] = '{32'hFFFE0001, 32'hFFFF0001, 32'hFFFF0001, 32'h0};
      logic [31:0] tp3 [4] = '{32'hFFFE0001, 32'hFFFF0001, 32'hFFFF0001, 32'hFFFF0000};
      logic [31:0] tp4 [4] = '{32'hFFFE0001, 32'h1, 32'h1, 32'h0};
      logic [2:0]  tfl [4] = '{3'b001, 3'b111, 3'b110, 3'b101};
      logic [31:0] twt [4] = '{32'hFFFFFFFE, 32'h0, 32'h1, 32'hFFFFFFFF};
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
        p1 = tp1[k]; p2 = tp2[k]; p3 = tp3[k]; p4 = tp4[k];
        {src1_signed, src2_signed, sel_hi} = tfl[k];
        in_valid = 1'b1;
        check("b2b in_ready", in_ready, 1);
        @(negedge clk);
        check("b2b out_valid", out_valid, 1);
        check("b2b result", result, twt[k]);
      end
      in_valid = 1'b0;
      @(negedge clk);
      out_ready = 1'b0;
      check("b2b drained", out_valid, 0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
